// File: rtl/rle_instr_encoder.sv
// rle_instr_encoder
// Run-length encoder that turns a raster stream of pixels into
// {color, run length} instructions for the video player's decoder.
// Runs never span lines (pix_eol closes them). A run saturates at MAX_RUN and
// the next same-color pixel opens a fresh run. A color change on an eol pixel
// closes two runs at once. The second run is emitted from the FLUSH state,
// which costs one cycle with pix_ready low.

module rle_instr_encoder #(
  parameter int COLOR_W = 9,
  parameter int RUN_W   = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [COLOR_W-1:0]         pix_color,
  input  logic                       pix_eol,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [COLOR_W+RUN_W-1:0]   instr_data
);

  localparam logic [RUN_W-1:0] MAX_RUN = '1;
  localparam logic [RUN_W-1:0] ONE     = RUN_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no open run
    RUN   = 2'd1,  // open run in run_color / run_cnt
    FLUSH = 2'd2   // open run must be emitted before any new pixel
  } state_t;

  state_t             state;
  logic [COLOR_W-1:0] run_color;
  logic [RUN_W-1:0]   run_cnt;

  logic               out_free;
  logic               accept;
  logic               same_color;
  logic [RUN_W-1:0]   next_cnt;

  // The output register can take a new instruction when it is empty or is
  // being drained on this edge. pix_ready depends on instr_ready but never on
  // pix_valid or pix_color, so the source may wait for ready before it offers
  // a pixel.
  assign out_free   = !instr_valid || instr_ready;
  assign pix_ready  = (state != FLUSH) && out_free;
  assign accept     = pix_valid && pix_ready;
  assign same_color = (pix_color == run_color);
  // run_cnt is at most MAX_RUN-1 while in RUN, so this sum cannot wrap.
  assign next_cnt   = run_cnt + ONE;

  // FSM, run tracking and output register, all updated on one edge.
  // NOTE: every register here is assigned with <= so that all branches read
  // the pre-edge values of state, run_cnt and instr_valid. Blocking
  // assignments would let a later branch see a half-updated run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: instr_data is reset together with the control state, even
      // though its value is don't-care while instr_valid is 0. Downstream
      // golden streams then start from a known, repeatable value.
      state       <= IDLE;
      run_color   <= '0;
      run_cnt     <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
    end else begin
      // A handshake empties the register. A load later in this block
      // overrides this, so back-to-back instructions leave no gap.
      if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            run_color <= pix_color;
            run_cnt   <= ONE;
            if (pix_eol || (ONE == MAX_RUN)) begin
              instr_valid <= 1'b1;
              instr_data  <= {pix_color, ONE};
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (accept) begin
            if (same_color) begin
              run_cnt <= next_cnt;
              if (pix_eol || (next_cnt == MAX_RUN)) begin
                instr_valid <= 1'b1;
                instr_data  <= {pix_color, next_cnt};
                state       <= IDLE;
              end
            end else begin
              // Close the old run and open a new one with this pixel.
              instr_valid <= 1'b1;
              instr_data  <= {run_color, run_cnt};
              run_color   <= pix_color;
              run_cnt     <= ONE;
              if (pix_eol) begin
                state <= FLUSH;
              end
            end
          end
        end

        FLUSH: begin
          // The run left open by an eol color change is always {color, 1}.
          if (out_free) begin
            instr_valid <= 1'b1;
            instr_data  <= {run_color, run_cnt};
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_instr_encoder.sv
// Self-checking bench for rle_instr_encoder.
// A stimulus process drives pixels. At each accepted pixel a run-length model
// pushes any instruction that pixel completes into a queue. A monitor pops that
// queue at every output handshake and compares it with instr_data.

module tb_rle_instr_encoder;

  localparam int COLOR_W = 9;
  localparam int RUN_W   = 11;
  localparam int DW      = COLOR_W + RUN_W;
  localparam int MAX_RUN = (1 << RUN_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               pix_valid;
  logic               pix_ready;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_eol;
  logic               instr_valid;
  logic               instr_ready;
  logic [DW-1:0]      instr_data;

  rle_instr_encoder #(.COLOR_W(COLOR_W), .RUN_W(RUN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_color   (pix_color),
    .pix_eol     (pix_eol),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int out_cnt   = 0;
  int stall_cnt = 0;
  bit count_en  = 1'b0;

  logic [DW-1:0] exp_q[$];

  // Reference model: the currently open run, if any.
  bit               m_open = 1'b0;
  logic [COLOR_W-1:0] m_color;
  int               m_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A pixel extends the open run when it has the same color and the run is
  // not yet full. Any other pixel closes the open run and starts a new one.
  // A run is written out when eol ends its line or when it reaches MAX_RUN.
  function automatic void model_accept(input logic [COLOR_W-1:0] c, input bit e);
    if (m_open && c == m_color) begin
      m_len++;
    end else begin
      if (m_open) exp_q.push_back({m_color, RUN_W'(m_len)});
      m_open  = 1'b1;
      m_color = c;
      m_len   = 1;
    end
    if (e || m_len == MAX_RUN) begin
      exp_q.push_back({m_color, RUN_W'(m_len)});
      m_open = 1'b0;
    end
  endfunction

  // Monitor: compare each delivered instruction and count stall cycles.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (count_en && !pix_ready) stall_cnt++;
      if (rst_n && instr_valid && instr_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got 0x%0h expected none (t=%0t)", instr_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("instr_data", 32'(instr_data), 32'(e));
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // Offer one pixel. The caller starts just after a rising edge; the task
  // returns just after the accepting edge.
  task automatic send_pixel(input logic [COLOR_W-1:0] c, input bit e);
    int waited = 0;
    pix_valid = 1'b1;
    pix_color = c;
    pix_eol   = e;
    @(negedge clk);
    while (!pix_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!pix_ready) begin
      check("pix_accept_timeout", 32'(pix_ready), 32'd1);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(c, e);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    m_open = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int c0;
    int o0;
    bit rand_done;
    logic [COLOR_W-1:0] palette [4];
    logic [COLOR_W-1:0] col;
    bit eol;

    rst_n       = 1'b0;
    pix_valid   = 1'b0;
    pix_color   = '0;
    pix_eol     = 1'b0;
    instr_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", 32'(instr_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_pix_ready", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1;

    // Five pixels of 0x1A4, eol on the fifth.
    for (int i = 0; i < 4; i++) send_pixel(9'h1A4, 1'b0);
    check("t1_no_early_valid", 32'(instr_valid), 32'd0);
    send_pixel(9'h1A4, 1'b1);
    check("t1_latency_valid", 32'(instr_valid), 32'd1);
    check("t1_latency_data", 32'(instr_data), 32'hD2005);
    drain();

    // A, A, B(eol): one FLUSH bubble.
    stall_cnt = 0;
    count_en  = 1'b1;
    send_pixel(9'h007, 1'b0);
    send_pixel(9'h007, 1'b0);
    send_pixel(9'h1C0, 1'b1);
    send_pixel(9'h0AA, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    count_en = 1'b0;
    check("t2_flush_bubble", 32'(stall_cnt), 32'd1);
    drain();

    // 2050 pixels of 0x000: saturation at MAX_RUN, then a fresh run of 3.
    for (int i = 0; i < 2050; i++) send_pixel(9'h000, i == 2049);
    drain();

    // Backpressure: hold an instruction for 10 cycles.
    instr_ready = 1'b0;
    send_pixel(9'h011, 1'b0);
    send_pixel(9'h022, 1'b0);
    pix_valid = 1'b1;
    pix_color = 9'h033;
    pix_eol   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_pix_ready", 32'(pix_ready), 32'd0);
      check("bp_instr_valid", 32'(instr_valid), 32'd1);
      check("bp_instr_data", 32'(instr_data), 32'h08801);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    send_pixel(9'h033, 1'b1);
    drain();

    // Reset mid-run: the open run is discarded.
    for (int i = 0; i < 3; i++) send_pixel(9'h155, 1'b0);
    check("rA_nothing_pending", 32'(exp_q.size()), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rA_valid_in_reset", 32'(instr_valid), 32'd0);
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rA_pix_ready_after", 32'(pix_ready), 32'd1);
    send_pixel(9'h0AA, 1'b1);
    check("rA_first_valid", 32'(instr_valid), 32'd1);
    check("rA_first_data", 32'(instr_data), 32'h55001);
    drain();

    // Reset with a pending instruction: it vanishes at once.
    instr_ready = 1'b0;
    send_pixel(9'h0AB, 1'b1);
    check("rB_pending", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rB_valid_cleared", 32'(instr_valid), 32'd0);
    check("rB_data_cleared", 32'(instr_data), 32'd0);
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;

    // Alternating colors, eol on every pixel: one pixel per cycle.
    c0 = cyc;
    o0 = out_cnt;
    stall_cnt = 0;
    count_en  = 1'b1;
    for (int i = 0; i < 100; i++) send_pixel((i % 2) ? 9'h0F0 : 9'h10F, 1'b1);
    check("alt_cycles", 32'(cyc - c0), 32'd100);
    repeat (2) @(posedge clk);
    #1;
    count_en = 1'b0;
    check("alt_out_count", 32'(out_cnt - o0), 32'd100);
    check("alt_no_stall", 32'(stall_cnt), 32'd0);
    drain();

    // Randomized stream with random sink backpressure and source gaps.
    palette[0] = 9'h000;
    palette[1] = 9'h1FF;
    palette[2] = 9'h0A5;
    palette[3] = 9'h15A;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          col = palette[$urandom_range(0, 3)];
          eol = ($urandom_range(0, 15) == 0) || (i == 2999);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_pixel(col, eol);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          instr_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
